// File: rtl/dwc_error_controller_if.sv
// Report/retry bus between the DwC error controller and the channel fabric.
// master = controller side, slave = channel/consumer side.
interface dwc_error_controller_if #(
  parameter int NUM_CH = 4
) ();
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0] port_error;
  logic [NUM_CH-1:0] port_retry;
  logic [NUM_CH-1:0] port_disable;
  logic              port_rep_valid;
  logic              port_rep_ready;
  logic [CW-1:0]     port_rep_ch;
  logic              port_rep_perm;
  logic              port_busy;

  modport master (
    input  port_error, port_rep_ready,
    output port_retry, port_rep_valid, port_rep_ch, port_rep_perm, port_disable, port_busy
  );

  modport slave (
    output port_error, port_rep_ready,
    input  port_retry, port_rep_valid, port_rep_ch, port_rep_perm, port_disable, port_busy
  );
endinterface

// File: rtl/dwc_error_controller.sv
// DwC error controller: round-robin retry/recheck of mismatching channels,
// classifying each fault as transient or permanent and masking permanent ones.
module dwc_error_controller #(
  parameter int NUM_CH      = 4,
  parameter int FAIL_THRESH = 3,
  parameter int RETRY_WAIT  = 2
) (
  input logic                   port_clk,
  input logic                   port_rst_n,
  dwc_error_controller_if.master bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [3:0] WAIT_INIT = 4'(RETRY_WAIT - 1);
  localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, RETRY, WAIT, CHECK, REPORT} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          ch_q, ch_d, rr_q, rr_d;
  logic [NUM_CH-1:0]      pend_q, pend_d, dis_q, dis_d;
  logic [NUM_CH-1:0][3:0] fcnt_q, fcnt_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic                   perm_q, perm_d;
  logic                   sel_found;
  logic [CW-1:0]          sel_idx;
  logic [NUM_CH-1:0]      svc;

  // First pending, enabled channel at or above rr_q, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!sel_found && pend_q[idx] && !dis_q[idx]) begin
        sel_found = 1'b1;
        sel_idx   = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    dis_d   = dis_q;
    fcnt_d  = fcnt_q;
    wcnt_d  = wcnt_q;
    perm_d  = perm_q;
    // The channel in service (or being granted this edge) never re-arms pending.
    if (state_q != IDLE) svc = ONE << ch_q;
    else if (sel_found)  svc = ONE << sel_idx;
    else                 svc = '0;
    pend_d = (pend_q | (bus.port_error & ~dis_q)) & ~svc;

    case (state_q)
      IDLE: if (sel_found) begin
        ch_d    = sel_idx;
        state_d = RETRY;
      end
      RETRY: begin
        wcnt_d  = WAIT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == 4'd0) state_d = CHECK;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      CHECK: begin
        if (!bus.port_error[ch_q]) begin
          fcnt_d[ch_q] = 4'd0;
          perm_d       = 1'b0;
          state_d      = REPORT;
        end else if (5'(fcnt_q[ch_q]) + 5'd1 < 5'(FAIL_THRESH)) begin
          fcnt_d[ch_q] = fcnt_q[ch_q] + 4'd1;
          state_d      = RETRY;
        end else begin
          dis_d[ch_q]  = 1'b1;
          fcnt_d[ch_q] = 4'd0;
          perm_d       = 1'b1;
          state_d      = REPORT;
        end
      end
      REPORT: if (bus.port_rep_ready) begin
        rr_d    = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + CW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pend_d = pend_d & ~dis_d;
  end

  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      rr_q    <= '0;
      pend_q  <= '0;
      dis_q   <= '0;
      fcnt_q  <= '0;
      wcnt_q  <= '0;
      perm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      dis_q   <= dis_d;
      fcnt_q  <= fcnt_d;
      wcnt_q  <= wcnt_d;
      perm_q  <= perm_d;
    end
  end

  assign bus.port_retry     = (state_q == RETRY) ? (ONE << ch_q) : '0;
  assign bus.port_rep_valid = (state_q == REPORT);
  assign bus.port_rep_ch    = ch_q;
  assign bus.port_rep_perm  = perm_q;
  assign bus.port_disable   = dis_q;
  assign bus.port_busy      = (state_q != IDLE);
endmodule

// File: doc/dwc_error_controller.md
DWC_ERROR_CONTROLLER -- requirements
Module: dwc_error_controller

Interface
REQ-001 Parameter NUM_CH, default 4: number of monitored DwC channels, 2..16.
REQ-002 Parameter FAIL_THRESH, default 3: consecutive failed rechecks that declare a channel permanent, 1..15.
REQ-003 Parameter RETRY_WAIT, default 2: cycles between retry pulse and recheck, 1..15.
REQ-004 port_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 port_rst_n  in  1  asynchronous, active-low reset.
REQ-006 port_error  in  NUM_CH  per-channel DwC mismatch flag, level, sampled every cycle.
REQ-007 port_retry  out  NUM_CH  one-hot, one-cycle pulse requesting recomputation on a channel.
REQ-008 port_rep_valid  out  1  error report available.
REQ-009 port_rep_ready  in  1  consumer accepts the report.
REQ-010 port_rep_ch  out  clog2(NUM_CH)  channel index of the report.
REQ-011 port_rep_perm  out  1  1 = permanent fault, 0 = transient fault (recovered).
REQ-012 port_disable  out  NUM_CH  sticky mask of permanently failed channels.
REQ-013 port_busy  out  1  high in every state except IDLE.

Function
REQ-014 Pending capture: pending[i] is set at the clock edge where port_error[i]=1, disable[i]=0 and i is not the channel in service.
- Error flags on the in-service channel are masked from pending.
REQ-015 FSM states: IDLE, RETRY, WAIT, CHECK, REPORT.
REQ-016 IDLE with any pending bit set goes to RETRY on the next edge. On that edge:
- latch the selected channel;
- clear its pending bit.
REQ-017 Selection is round-robin: first pending index at or above rr_ptr, wrapping modulo NUM_CH.
REQ-018 RETRY lasts exactly 1 cycle and drives port_retry[ch]=1; it then goes to WAIT.
- port_retry is 0 in every other state.
REQ-019 WAIT lasts exactly RETRY_WAIT cycles and then goes to CHECK.
REQ-020 CHECK lasts 1 cycle and samples port_error[ch]:
- 0: go to REPORT with perm=0, fail_cnt[ch] cleared to 0;
- 1 and fail_cnt[ch]+1 < FAIL_THRESH: increment fail_cnt[ch], go to RETRY;
- 1 and fail_cnt[ch]+1 >= FAIL_THRESH: set disable[ch], clear fail_cnt[ch], go to REPORT with perm=1.
REQ-021 fail_cnt is a per-channel 4-bit counter.
- It never exceeds FAIL_THRESH-1.
- It is only modified in CHECK.
REQ-022 REPORT holds port_rep_valid=1 until port_rep_ready=1.
- port_rep_ch and port_rep_perm stay stable while valid is high.
- Valid deasserts on the edge after the handshake.
- port_rep_valid is 0 in every other state.
REQ-023 On the REPORT handshake edge:
- rr_ptr <= (ch+1) mod NUM_CH;
- state <= IDLE.
- A new grant starts no earlier than the next IDLE cycle.
REQ-024 A disabled channel never sets pending again and is never selected.
- Its pending bit is cleared on the edge where it becomes disabled.
REQ-025 Minimum latency, error to report:
- error at cycle t;
- pending at t+1;
- RETRY at t+2;
- CHECK at t+3+RETRY_WAIT;
- REPORT valid at t+4+RETRY_WAIT.
REQ-026 Pending events on other channels that arrive while busy are retained and served in round-robin order afterwards.

Reset
REQ-027 port_rst_n=0 immediately forces:
- state=IDLE;
- pending=0, fail_cnt=0, rr_ptr=0, disable=0;
- all outputs 0.
REQ-028 Reset asserted mid-sequence (any non-IDLE state) aborts the sequence with no report issued.
- Operation resumes from IDLE on the first edge after deassertion.

Verification
REQ-029 port_error[1] pulses one cycle, recheck clean -> one port_retry[1] pulse; then report ch=1, perm=0 at t+6 (RETRY_WAIT=2); disable=0.
REQ-030 port_error[2] held high -> exactly 3 port_retry[2] pulses, then report ch=2, perm=1; disable=4'b0100; later port_error[2] ignored, port_busy stays 0.
REQ-031 port_error[0] and port_error[3] rise in the same cycle, rr_ptr=0 -> ch 0 served first; ch 3 served after handshake; next pair starts at rr_ptr=0 after ch3 report (wrap).
REQ-032 Report for ch=1 with port_rep_ready=0 for 5 cycles -> valid, ch, perm stable 5 cycles; single handshake; meanwhile new port_error[2] is held pending and served next.
REQ-033 Reset pulsed during WAIT for ch=2 with fail_cnt=1 -> no report; all outputs 0, fail_cnt[2]=0 after release.
REQ-034 Error fails 2 rechecks then clears -> report perm=0; fail_cnt[ch]=0; a later persistent error needs a full 3 failures for perm=1.
